// File: rtl/rst_pulse_gen_if.sv
// Request/status bundle between a reset-request source and rst_pulse_gen.
// With RST_PULSE_CNT_EN defined it also carries the 8-bit pulse counter.
interface rst_pulse_gen_if;
    logic       req;
    logic       rst_out;
    logic       busy;
    logic       done;
`ifdef RST_PULSE_CNT_EN
    logic [7:0] pulse_cnt;

    modport master (output req, input rst_out, input busy, input done, input pulse_cnt);
    modport slave  (input req, output rst_out, output busy, output done, output pulse_cnt);
`else
    modport master (output req, input rst_out, input busy, input done);
    modport slave  (input req, output rst_out, output busy, output done);
`endif
endinterface

// File: rtl/rst_pulse_gen.sv
// Turns a bouncy asynchronous request into one clean fixed-length reset pulse.
// Optional feature macro: RST_PULSE_CNT_EN (saturating count of issued pulses).
module rst_pulse_gen #(
    parameter int DEB_CYCLES = 4,
    parameter int PULSE_LEN  = 16,
    parameter int CNT_W      = 8
) (
    input  logic           clk,
    input  logic           rst,
    rst_pulse_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        ASSERT   = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_s1;
    logic             r_req_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rst_out;
    logic             r_busy;
    logic             r_done;
`ifdef RST_PULSE_CNT_EN
    logic [7:0]       r_pulse_cnt;
`endif

    // Two-flop synchronizer for the asynchronous request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_req_s <= 1'b0;
        end else begin
            r_s1    <= bus.req;
            r_req_s <= r_s1;
        end
    end

    // Debounce / pulse FSM; every output is registered with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= CNT_ZERO;
            r_rst_out <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt     <= CNT_ZERO;
                    r_rst_out <= 1'b0;
                    r_done    <= 1'b0;
                    if (r_req_s) begin
                        r_state <= DEBOUNCE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                DEBOUNCE: begin
                    r_done <= 1'b0;
                    // Any low sample restarts the whole debounce from IDLE.
                    if (!r_req_s) begin
                        r_state   <= IDLE;
                        r_cnt     <= CNT_ZERO;
                        r_rst_out <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state   <= ASSERT;
                        r_cnt     <= CNT_ZERO;
                        r_rst_out <= 1'b1;
                        r_busy    <= 1'b1;
                    end else begin
                        r_state   <= DEBOUNCE;
                        r_cnt     <= r_cnt + CNT_ONE;
                        r_rst_out <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                ASSERT: begin
                    r_busy <= 1'b1;
                    if (r_cnt == PULSE_LAST) begin
                        r_state   <= RELEASE;
                        r_cnt     <= CNT_ZERO;
                        r_rst_out <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_state   <= ASSERT;
                        r_cnt     <= r_cnt + CNT_ONE;
                        r_rst_out <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                RELEASE: begin
                    r_cnt     <= CNT_ZERO;
                    r_rst_out <= 1'b0;
                    r_done    <= 1'b0;
                    // Held request must drop before another pulse can be armed.
                    if (!r_req_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= RELEASE;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_cnt     <= CNT_ZERO;
                    r_rst_out <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

`ifdef RST_PULSE_CNT_EN
    // Saturating pulse counter, stepping on the edge that raises done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse_cnt <= 8'h00;
        end else if (r_state == ASSERT && r_cnt == PULSE_LAST && r_pulse_cnt != 8'hFF) begin
            r_pulse_cnt <= r_pulse_cnt + 8'h01;
        end else begin
            r_pulse_cnt <= r_pulse_cnt;
        end
    end

    assign bus.pulse_cnt = r_pulse_cnt;
`endif

    assign bus.rst_out = r_rst_out;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_rst_pulse_gen.sv
// Directed bench for rst_pulse_gen: run-length table of per-edge expectations
// plus hand-written sequences for hold, latency, short-parameter and counter cases.
module tb_rst_pulse_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    rst_pulse_gen_if bus ();
    rst_pulse_gen_if bus1 ();

    rst_pulse_gen #(.DEB_CYCLES(4), .PULSE_LEN(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    rst_pulse_gen #(.DEB_CYCLES(1), .PULSE_LEN(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct {
        logic req;
        logic rst;
        int   n;
        logic ro;
        logic busy;
        logic done;
    } seg_t;

    seg_t tbl[$];

    task automatic add(input logic rq, input logic rs, input int n,
                       input logic ro, input logic bz, input logic dn);
        seg_t s;
        s.req = rq; s.rst = rs; s.n = n; s.ro = ro; s.busy = bz; s.done = dn;
        tbl.push_back(s);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Full press with defaults, request held 'hold' edges in total (>=23).
    task automatic add_press(input int hold);
        add(1'b1, 1'b0, 2,  1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 4,  1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 16, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b1);
        add(1'b1, 1'b0, hold - 23, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 2,  1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 3,  1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int pulses, highs, dones, lat;
        logic prev_ro;

        bus.req  = 1'b0;
        bus1.req = 1'b0;

        // Reset with req high: nothing may leave IDLE.
        add(1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
        // Clean press held 40 edges.
        add_press(40);
        // Bounce: high 2, low 1, high 2, low.
        add(1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4, 1'b0, 0, 1'b0);
        // Reset during the 5th cycle of rst_out, then a fresh debounce.
        add(1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        add_press(25);
        // Press again after release: full latency again.
        add_press(30);

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                bus.req = tbl[i].req;
                rst     = tbl[i].rst;
                edge1();
                check($sformatf("seg%0d.%0d rst_out", i, k), int'(bus.rst_out), int'(tbl[i].ro));
                check($sformatf("seg%0d.%0d busy", i, k), int'(bus.busy), int'(tbl[i].busy));
                check($sformatf("seg%0d.%0d done", i, k), int'(bus.done), int'(tbl[i].done));
            end
        end

        // Hold 100 edges: exactly one 16-cycle pulse and one done.
        pulses = 0; highs = 0; dones = 0; prev_ro = 1'b0;
        bus.req = 1'b1;
        for (int k = 0; k < 100; k++) begin
            edge1();
            if (bus.rst_out && !prev_ro) pulses++;
            if (bus.rst_out) highs++;
            if (bus.done) dones++;
            prev_ro = bus.rst_out;
        end
        bus.req = 1'b0;
        for (int k = 0; k < 6; k++) edge1();
        check("hold pulses", pulses, 1);
        check("hold high cycles", highs, 16);
        check("hold done cycles", dones, 1);
        check("hold busy after release", int'(bus.busy), 0);

        // Second press: rst_out rises after the 7th edge.
        bus.req = 1'b1;
        lat = 0;
        while (bus.rst_out !== 1'b1 && lat < 50) begin
            edge1();
            lat++;
        end
        check("repress latency", lat, 7);
        for (int k = 0; k < 30; k++) edge1();
        bus.req = 1'b0;
        for (int k = 0; k < 6; k++) edge1();
        check("repress idle", int'(bus.busy), 0);

        // Minimum parameters: pulse after 4th edge, one cycle wide, done next.
        for (int k = 1; k <= 10; k++) begin
            bus1.req = (k <= 6) ? 1'b1 : 1'b0;
            edge1();
            check($sformatf("min e%0d rst_out", k), int'(bus1.rst_out), (k == 4) ? 1 : 0);
            check($sformatf("min e%0d done", k), int'(bus1.done), (k == 5) ? 1 : 0);
        end

`ifdef RST_PULSE_CNT_EN
        rst = 1'b1;
        edge1();
        rst = 1'b0;
        check("pcnt after rst", int'(bus.pulse_cnt), 0);
        for (int p = 0; p < 3; p++) begin
            bus.req = 1'b1;
            for (int k = 0; k < 30; k++) edge1();
            bus.req = 1'b0;
            for (int k = 0; k < 6; k++) edge1();
        end
        check("pcnt three presses", int'(bus.pulse_cnt), 3);
        for (int p = 0; p < 260; p++) begin
            bus1.req = 1'b1;
            for (int k = 0; k < 6; k++) edge1();
            bus1.req = 1'b0;
            for (int k = 0; k < 4; k++) edge1();
        end
        check("pcnt saturate", int'(bus1.pulse_cnt), 255);
        rst = 1'b1;
        edge1();
        rst = 1'b0;
        check("pcnt cleared", int'(bus1.pulse_cnt), 0);
        check("pcnt main cleared", int'(bus.pulse_cnt), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
